node_out_arbiter: RTL and testbench

Per-output-port wormhole arbiter for a mesh router node. It shares one output link among NUM_PORTS input ports (NORTH, SOUTH, EAST, WEST, LOCAL). Grants are round-robin and per packet: a head flit wins the link, and the link stays locked to that input until its tail flit transfers. A stall watchdog releases the lock if the owning input stops supplying flits. One instance sits in front of each output port of a node.

---
 rtl/node_out_arbiter.sv | 131 +++++++++++++
 tb/tb_node_out_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/node_out_arbiter.sv
// Wormhole output arbiter: round-robin per-packet grant of one output link,
// held until the owner's tail transfers or a stall watchdog forces release.
`timescale 1ns/1ps

module node_out_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int TIMEOUT   = 16,
    parameter int TO_W      = 5,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] head_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 out_ready_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 out_valid_o,
    output logic [NUM_PORTS-1:0] ready_o,
    output logic                 locked_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     pkt_cnt_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   prio_q, prio_d;
    logic [TO_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic               tmo_q, tmo_d;

    logic [NUM_PORTS-1:0] cand;
    logic                 found;
    logic [SEL_W-1:0]     pick;
    logic [SEL_W-1:0]     idx;
    logic                 xfer;

    function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
        if (p == SEL_W'(NUM_PORTS - 1))
            return '0;
        else
            return p + SEL_W'(1);
    endfunction

    assign cand = req_i & head_i;

    // Circular search starting at the priority pointer; first head request wins.
    always_comb begin
        found = 1'b0;
        pick  = prio_q;
        idx   = prio_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = next_port(idx);
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign grant_o     = locked_o ? (NUM_PORTS'(1) << owner_q) : '0;
    assign out_valid_o = locked_o & req_i[owner_q];
    assign ready_o     = grant_o & {NUM_PORTS{out_ready_i}};
    assign sel_o       = owner_q;
    assign timeout_o   = tmo_q;
    assign pkt_cnt_o   = pkt_q;
    assign xfer        = out_valid_o & out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= '0;
            stall_q <= '0;
            pkt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            stall_q <= stall_d;
            pkt_q   <= pkt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Only an absent owner flit advances the watchdog; backpressure never does.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        stall_d = stall_q;
        pkt_d   = pkt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    stall_d = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    stall_d = '0;
                    if (tail_i[owner_q]) begin
                        state_d = IDLE;
                        prio_d  = next_port(owner_q);
                        pkt_d   = pkt_q + CNT_W'(1);
                    end
                end else if (!req_i[owner_q]) begin
                    if (stall_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        prio_d  = next_port(owner_q);
                        stall_d = '0;
                        tmo_d   = 1'b1;
                    end else begin
                        stall_d = stall_q + TO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_node_out_arbiter.sv
// Table-driven bench for node_out_arbiter: one record per clock cycle with
// hand-computed outputs, plus an asynchronous mid-packet reset sequence.
`timescale 1ns/1ps

module tb_node_out_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req_i, head_i, tail_i;
    logic       out_ready_i;
    logic [4:0] grant_o, ready_o;
    logic [2:0] sel_o;
    logic       out_valid_o, locked_o, timeout_o;
    logic [15:0] pkt_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]  req;
        logic [4:0]  head;
        logic [4:0]  tail;
        logic        rdy;
        logic [4:0]  grant;
        logic [2:0]  sel;
        logic        valid;
        logic        locked;
        logic        tmo;
        logic [15:0] pkt;
    } vec_t;

    vec_t tbl[$];

    node_out_arbiter #(.NUM_PORTS(5), .TIMEOUT(16), .TO_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
        .out_ready_i(out_ready_i), .grant_o(grant_o), .sel_o(sel_o),
        .out_valid_o(out_valid_o), .ready_o(ready_o), .locked_o(locked_o),
        .timeout_o(timeout_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [4:0] req, logic [4:0] head, logic [4:0] tail,
                                logic rdy, logic [4:0] grant, logic [2:0] sel,
                                logic valid, logic locked, logic tmo, logic [15:0] pkt);
        vec_t v;
        v.req = req; v.head = head; v.tail = tail; v.rdy = rdy;
        v.grant = grant; v.sel = sel; v.valid = valid; v.locked = locked;
        v.tmo = tmo; v.pkt = pkt;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_i       = v.req;
        head_i      = v.head;
        tail_i      = v.tail;
        out_ready_i = v.rdy;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        cmp({name, ".grant"},  32'(grant_o),     32'(v.grant));
        cmp({name, ".sel"},    32'(sel_o),       32'(v.sel));
        cmp({name, ".valid"},  32'(out_valid_o), 32'(v.valid));
        cmp({name, ".ready"},  32'(ready_o),     32'(v.grant & {5{v.rdy}}));
        cmp({name, ".locked"}, 32'(locked_o),    32'(v.locked));
        cmp({name, ".tmo"},    32'(timeout_o),   32'(v.tmo));
        cmp({name, ".pkt"},    32'(pkt_cnt_o),   32'(v.pkt));
    endtask

    task automatic runTable(input string name);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d]", name, i), tbl[i]);
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic resetDut();
        applyStimulus(mk(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", mk(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0));
        rst = 1'b0;
    endtask

    initial begin
        int owner;
        int last;
        int ord[3];
        ord[0] = 0; ord[1] = 1; ord[2] = 4;
        #1;
        resetDut();

        $display("[TB] single requester, then prio check");
        tbl.push_back(mk(5'b00100, 5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5'b00100, 5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 2, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00100, 5'b00000, 5'b00100, 1, 5'b00100, 2, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0, 0, 1));
        tbl.push_back(mk(5'b10010, 5'b10010, 5'b10010, 1, 5'b00000, 2, 0, 0, 0, 1));
        tbl.push_back(mk(5'b10010, 5'b10010, 5'b10010, 1, 5'b10000, 4, 1, 1, 0, 1));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00010, 1, 5'b00000, 4, 0, 0, 0, 2));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00010, 1, 5'b00010, 1, 1, 1, 0, 2));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0, 0, 0, 3));
        runTable("single");

        $display("[TB] asynchronous reset mid-packet");
        tbl.push_back(mk(5'b10000, 5'b10000, 5'b00000, 1, 5'b00000, 1, 0, 0, 0, 3));
        tbl.push_back(mk(5'b10000, 5'b10000, 5'b00000, 1, 5'b10000, 4, 1, 1, 0, 3));
        tbl.push_back(mk(5'b10000, 5'b00000, 5'b00000, 1, 5'b10000, 4, 1, 1, 0, 3));
        runTable("prerst");
        applyStimulus(mk(5'b10000, 5'b00000, 5'b00000, 1, 5'b0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("flit2", mk(5'b10000, 5'b00000, 5'b00000, 1, 5'b10000, 4, 1, 1, 0, 3));
        #1 rst = 1'b1;
        #1 checkOutput("asyncrst", mk(5'b10000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;
        tbl.push_back(mk(5'b10000, 5'b10000, 5'b10000, 1, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5'b10000, 5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 4, 0, 0, 0, 1));
        runTable("postrst");

        $display("[TB] round-robin fairness");
        resetDut();
        last = 0;
        for (int c = 0; c < 12; c++) begin
            if (c % 2 == 1) begin
                owner = ord[((c - 1) / 2) % 3];
                tbl.push_back(mk(5'b10011, 5'b10011, 5'b10011, 1, 5'(1 << owner),
                                 3'(owner), 1, 1, 0, 16'((c - 1) / 2)));
                last = owner;
            end else begin
                tbl.push_back(mk(5'b10011, 5'b10011, 5'b10011, 1, 5'b00000,
                                 3'(last), 0, 0, 0, 16'(c / 2)));
            end
        end
        runTable("rr");

        $display("[TB] wormhole lock");
        resetDut();
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5'b00011, 5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00011, 5'b00001, 5'b00000, 1, 5'b00010, 1, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00011, 5'b00001, 5'b00010, 1, 5'b00010, 1, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 1, 0, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0, 2));
        runTable("worm");

        $display("[TB] backpressure does not time out");
        resetDut();
        tbl.push_back(mk(5'b01000, 5'b01000, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 40; c++)
            tbl.push_back(mk(5'b01000, 5'b01000, 5'b00000, 0, 5'b01000, 3, 1, 1, 0, 0));
        tbl.push_back(mk(5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 3, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0, 0, 0, 1));
        runTable("bp");

        $display("[TB] watchdog release");
        resetDut();
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 0, 1, 1, 0, 0));
        for (int c = 2; c <= 17; c++)
            tbl.push_back(mk(5'b00010, 5'b00010, 5'b00000, 1, 5'b00001, 0, 0, 1, 0, 0));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00010, 1, 5'b00010, 1, 1, 1, 0, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0, 0, 0, 1));
        runTable("wdog");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
